// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// steps, then one sign-fixup cycle, under a start/busy/done handshake.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  func_3,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [2:0]  func_q;
    logic        neg_q;
    logic        sign_a_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result_q;

    logic        accept;
    logic        signed_a;
    logic        signed_b;
    logic        sa;
    logic        sb;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] sub;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] fin_val;
    logic        fin_ok;

    assign accept   = (state == IDLE) && start && !flush;
    assign signed_a = (func_3 == 3'b001) || (func_3 == 3'b010) ||
                      (func_3 == 3'b100) || (func_3 == 3'b110);
    assign signed_b = (func_3 == 3'b001) || (func_3 == 3'b100) ||
                      (func_3 == 3'b110);
    assign sa       = signed_a && op_1[31];
    assign sb       = signed_b && op_2[31];

    assign sum      = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : 33'd0);
    // 33-bit partial remainder: previous remainder with next dividend bit
    assign shifted  = {hi, lo[31]};
    assign ge       = shifted >= {1'b0, b_q};
    assign sub      = shifted[31:0] - b_q;

    assign prod_s   = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_s    = (b_q == 32'd0) ? 32'hFFFF_FFFF
                    : (neg_q ? -lo : lo);
    // Divide-by-zero leaves the dividend magnitude here, so this restores op_1
    assign rem_s    = sign_a_q ? -hi : hi;

    always_comb begin
        fin_val = 32'd0;
        case (func_q)
            3'b000:                 fin_val = prod_s[31:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_s[63:32];
            3'b100, 3'b101:         fin_val = quo_s;
            default:                fin_val = rem_s;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_next = CALC;
                CALC:    if (cnt == 6'd31) state_next = FIN;
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 6'd0;
            func_q   <= 3'd0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (accept) begin
            cnt      <= 6'd0;
            func_q   <= func_3;
            neg_q    <= sa ^ sb;
            sign_a_q <= sa;
            a_q      <= sa ? -op_1 : op_1;
            b_q      <= sb ? -op_2 : op_2;
            hi       <= 32'd0;
            lo       <= func_3[2] ? (sa ? -op_1 : op_1)
                                  : (sb ? -op_2 : op_2);
        end else if (state == CALC && !flush) begin
            cnt <= cnt + 6'd1;
            if (!func_q[2]) begin
                hi <= sum[32:1];
                lo <= {sum[0], lo[31:1]};
            end else begin
                hi <= ge ? sub : shifted[31:0];
                lo <= {lo[30:0], ge};
            end
        end
    end

    assign fin_ok = (state == FIN) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      result_q <= 32'd0;
        else if (fin_ok) result_q <= fin_val;
    end

    assign busy   = (state != IDLE);
    assign done   = fin_ok;
    assign result = fin_ok ? fin_val : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases,
// latency, back-to-back start, flush and asynchronous reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func_3 = 3'd0;
    logic [31:0] op_1 = 32'd0;
    logic [31:0] op_2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .func_3 (func_3),
        .op_1   (op_1),
        .op_2   (op_2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int done_at;
        int done_cnt;
        int busy_cnt;
        logic [31:0] res_at;
        done_at  = 0;
        done_cnt = 0;
        busy_cnt = 0;
        res_at   = 32'd0;
        @(posedge clk); #1;
        start = 1'b1; func_3 = f; op_1 = a; op_2 = b;
        @(posedge clk); #1;
        start = 1'b0; op_1 = $urandom; op_2 = $urandom;
        func_3 = 3'($urandom_range(7));
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = c;
                    res_at  = result;
                end
            end
        end
        checks++;
        if (res_at !== exp) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", name, res_at, exp);
        end
        checks++;
        if (done_at !== 33 || done_cnt !== 1) begin
            failures++;
            $display("FAIL %s latency got=%0d pulses=%0d exp=33/1",
                     name, done_at, done_cnt);
        end
        checks++;
        if (busy_cnt !== 33) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=33", name, busy_cnt);
        end
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL %s result_hold got=%h exp=%h", name, result, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got=%b/%b/%h exp=0/0/0",
                     busy, done, result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg");
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, "divu");
    endtask

    task automatic test_special();
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by0");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    endtask

    task automatic test_back_to_back();
        int rises[8];
        int n_rise;
        int n_done;
        logic prev_busy;
        n_rise = 0;
        n_done = 0;
        prev_busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; func_3 = 3'b000; op_1 = 32'd3; op_2 = 32'd4;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (busy && !prev_busy && n_rise < 8) begin
                rises[n_rise] = c;
                n_rise++;
            end
            if (done) begin
                n_done++;
                checks++;
                if (result !== 32'd12) begin
                    failures++;
                    $display("FAIL b2b_result got=%h exp=0000000c", result);
                end
            end
            prev_busy = busy;
            if (c == 110) start = 1'b0;
        end
        checks++;
        if (n_rise !== 4 || n_done !== 4) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d dones=%0d exp=4/4",
                     n_rise, n_done);
        end
        for (int i = 1; i < n_rise && i < 4; i++) begin
            checks++;
            if (rises[i] - rises[i-1] !== 34) begin
                failures++;
                $display("FAIL b2b_period got=%0d exp=34",
                         rises[i] - rises[i-1]);
            end
        end
    endtask

    task automatic test_flush();
        int n_done;
        n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; func_3 = 3'b101; op_1 = 32'd100; op_2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        if (done) n_done++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy got=%b exp=0", busy);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL flush_done got=%0d pulses exp=0", n_done);
        end
        checks++;
        if (result !== 32'd12) begin
            failures++;
            $display("FAIL flush_result got=%h exp=0000000c", result);
        end
    endtask

    task automatic test_async_reset();
        int n_done;
        n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; func_3 = 3'b000; op_1 = 32'd7; op_2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%h exp=0/0/0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL reset_lost_op got=%0d active cycles exp=0", n_done);
        end
        run_op(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
